cluster_pass_scheduler: RTL

- Sequences the cluster encoder passes for each bunch crossing, driven by the per-bx cluster count from the VPF counting tree. Runs on clock4x.
- Converts a count into a number of encoder passes of CLUSTERS_PER_PASS clusters each, capped at MAX_PASSES. Issues the passes over a req/ack handshake with a watchdog timeout.
- Reports the per-frame cluster total, overflow and timeout status.
- Buffers one pending count while busy and counts dropped counts.

---
 rtl/cluster_pass_scheduler.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/cluster_pass_scheduler.sv
// Cluster encoder pass sequencer: turns a per-bx cluster count into capped encoder
// passes over a req/ack handshake with a watchdog, plus a one-deep pending count slot.
module cluster_pass_scheduler #(
    parameter int unsigned CNT_WIDTH         = 11,
    parameter int unsigned CLUSTERS_PER_PASS = 8,
    parameter int unsigned MAX_PASSES        = 2,
    parameter int unsigned TIMEOUT           = 15
) (
    input  logic                 clock4x,
    input  logic                 reset,
    input  logic [CNT_WIDTH-1:0] cnt_i,
    input  logic                 cnt_valid_i,
    input  logic                 pass_ack_i,
    output logic                 pass_req_o,
    output logic [3:0]           pass_idx_o,
    output logic                 frame_done_o,
    output logic [CNT_WIDTH-1:0] n_clusters_o,
    output logic                 overflow_o,
    output logic                 timeout_o,
    output logic                 busy_o,
    output logic [7:0]           drop_cnt_o
);

    localparam int unsigned       CW1     = CNT_WIDTH + 1;
    localparam logic [CW1-1:0]    CAP_W   = CW1'(CLUSTERS_PER_PASS * MAX_PASSES);
    localparam logic [CW1-1:0]    CPP_W   = CW1'(CLUSTERS_PER_PASS);
    localparam logic [7:0]        WD_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_FINISH} state_t;

    state_t               r_state,    w_state_n;
    logic [CW1-1:0]       r_capped,   w_capped_n;
    logic                 r_ovf_f,    w_ovf_f_n;
    logic [3:0]           r_passes,   w_passes_n;
    logic [3:0]           r_acked,    w_acked_n;
    logic [7:0]           r_wdog,     w_wdog_n;
    logic                 r_tflag,    w_tflag_n;
    logic                 r_pend_v,   w_pend_v_n;
    logic [CNT_WIDTH-1:0] r_pend_cnt, w_pend_cnt_n;
    logic [7:0]           r_drop,     w_drop_n;
    logic                 r_req,      w_req_n;
    logic [3:0]           r_idx,      w_idx_n;
    logic                 r_done,     w_done_n;
    logic [CNT_WIDTH-1:0] r_ncl,      w_ncl_n;
    logic                 r_ovf,      w_ovf_n;
    logic                 r_to,       w_to_n;
    logic                 r_busy,     w_busy_n;

    logic [CNT_WIDTH-1:0] w_src;
    logic [CW1-1:0]       w_src_ext;
    logic [CW1-1:0]       w_capped;
    logic [3:0]           w_passes;
    logic [3:0]           w_ack_inc;
    logic [CW1-1:0]       w_deliv;
    logic [CW1-1:0]       w_deliv_min;

    // Pending count takes priority over a fresh strobe when a frame starts.
    assign w_src       = r_pend_v ? r_pend_cnt : cnt_i;
    assign w_src_ext   = CW1'(w_src);
    assign w_capped    = (w_src_ext > CAP_W) ? CAP_W : w_src_ext;
    assign w_passes    = 4'((w_capped + CPP_W - CW1'(1)) / CPP_W);
    assign w_ack_inc   = r_acked + 4'd1;
    assign w_deliv     = CW1'(r_acked) * CPP_W;
    assign w_deliv_min = (w_deliv < r_capped) ? w_deliv : r_capped;

    always_ff @(posedge clock4x or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_capped   <= '0;
            r_ovf_f    <= 1'b0;
            r_passes   <= '0;
            r_acked    <= '0;
            r_wdog     <= '0;
            r_tflag    <= 1'b0;
            r_pend_v   <= 1'b0;
            r_pend_cnt <= '0;
            r_drop     <= '0;
            r_req      <= 1'b0;
            r_idx      <= '0;
            r_done     <= 1'b0;
            r_ncl      <= '0;
            r_ovf      <= 1'b0;
            r_to       <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_capped   <= w_capped_n;
            r_ovf_f    <= w_ovf_f_n;
            r_passes   <= w_passes_n;
            r_acked    <= w_acked_n;
            r_wdog     <= w_wdog_n;
            r_tflag    <= w_tflag_n;
            r_pend_v   <= w_pend_v_n;
            r_pend_cnt <= w_pend_cnt_n;
            r_drop     <= w_drop_n;
            r_req      <= w_req_n;
            r_idx      <= w_idx_n;
            r_done     <= w_done_n;
            r_ncl      <= w_ncl_n;
            r_ovf      <= w_ovf_n;
            r_to       <= w_to_n;
            r_busy     <= w_busy_n;
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_capped_n   = r_capped;
        w_ovf_f_n    = r_ovf_f;
        w_passes_n   = r_passes;
        w_acked_n    = r_acked;
        w_wdog_n     = r_wdog;
        w_tflag_n    = r_tflag;
        w_pend_v_n   = r_pend_v;
        w_pend_cnt_n = r_pend_cnt;
        w_drop_n     = r_drop;
        w_req_n      = r_req;
        w_idx_n      = r_idx;
        w_done_n     = 1'b0;
        w_ncl_n      = r_ncl;
        w_ovf_n      = r_ovf;
        w_to_n       = r_to;

        case (r_state)
            S_IDLE: begin
                if (cnt_valid_i || r_pend_v) begin
                    w_capped_n   = w_capped;
                    w_ovf_f_n    = (w_src_ext > CAP_W);
                    w_passes_n   = w_passes;
                    w_acked_n    = '0;
                    w_wdog_n     = '0;
                    w_tflag_n    = 1'b0;
                    w_idx_n      = '0;
                    w_pend_v_n   = r_pend_v && cnt_valid_i;
                    w_pend_cnt_n = cnt_valid_i ? cnt_i : r_pend_cnt;
                    if (w_passes != 4'd0) begin
                        w_state_n = S_ISSUE;
                        w_req_n   = 1'b1;
                    end else begin
                        w_state_n = S_FINISH;
                    end
                end
            end
            S_ISSUE: begin
                if (pass_ack_i) begin
                    w_acked_n = w_ack_inc;
                    w_wdog_n  = '0;
                    if (w_ack_inc < r_passes) begin
                        w_idx_n = r_idx + 4'd1;
                    end else begin
                        w_req_n   = 1'b0;
                        w_state_n = S_FINISH;
                    end
                end else if (r_wdog == WD_LAST) begin
                    w_req_n   = 1'b0;
                    w_tflag_n = 1'b1;
                    w_state_n = S_FINISH;
                end else begin
                    w_wdog_n = r_wdog + 8'd1;
                end
            end
            S_FINISH: begin
                w_done_n  = 1'b1;
                w_ncl_n   = CNT_WIDTH'(r_tflag ? w_deliv_min : r_capped);
                w_ovf_n   = r_ovf_f;
                w_to_n    = r_tflag;
                w_state_n = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase

        // While busy a strobe fills the empty slot or is dropped.
        if (r_state != S_IDLE && cnt_valid_i) begin
            if (!r_pend_v) begin
                w_pend_v_n   = 1'b1;
                w_pend_cnt_n = cnt_i;
            end else if (r_drop != 8'hFF) begin
                w_drop_n = r_drop + 8'd1;
            end
        end

        w_busy_n = (w_state_n != S_IDLE);
    end

    assign pass_req_o   = r_req;
    assign pass_idx_o   = r_idx;
    assign frame_done_o = r_done;
    assign n_clusters_o = r_ncl;
    assign overflow_o   = r_ovf;
    assign timeout_o    = r_to;
    assign busy_o       = r_busy;
    assign drop_cnt_o   = r_drop;

endmodule
